// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one single-port SRAM between host loader (0), RC4 (1), Sobel (2).
// Latency: gnt is combinational in T; mem_* strobes are registered (T+1); rvalid/rdata arrive at T+1+READ_LAT.
// Backpressure: requesters hold req/we/addr/wdata until gnt; a locked owner blocks the others for up to MAX_BURST accesses.
// Ports: clk/rst/abort control; req/lock/we/addr/wdata per-port request side (port i at slice i);
//        gnt/rvalid one-hot per port, rdata shared, busy status; mem_* drive the SRAM controller.
module sram_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int READ_LAT  = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                abort,
    input  logic [2:0]          req,
    input  logic [2:0]          lock,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {ARB = 1'b0, OWNED = 1'b1} state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] port;
    } tag_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             gnt_vld;
    logic [1:0]       gnt_port;
    logic [1:0]       cand;
    tag_t             tag_q [READ_LAT];
    logic             any_tag;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and grant selection. rst and abort both suppress the grant
    // so nothing is accepted in a flush cycle.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        gnt_vld  = 1'b0;
        gnt_port = 2'd0;
        cand     = ptr_q;
        if (rst || abort) begin
            state_d = ARB;
            ptr_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ARB: begin
                    // First requester at or after ptr, wrapping mod 3.
                    for (int k = 0; k < 3; k++) begin
                        if (!gnt_vld && req[cand]) begin
                            gnt_vld  = 1'b1;
                            gnt_port = cand;
                        end
                        cand = inc3(cand);
                    end
                    if (gnt_vld) begin
                        if (lock[gnt_port] && (MAX_BURST > 1)) begin
                            state_d = OWNED;
                            owner_d = gnt_port;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            ptr_d = inc3(gnt_port);
                        end
                    end
                end
                OWNED: begin
                    if (req[owner_q]) begin
                        gnt_vld  = 1'b1;
                        gnt_port = owner_q;
                        cnt_d    = cnt_inc;
                        if (!lock[owner_q] || (cnt_inc == CNT_W'(MAX_BURST))) begin
                            state_d = ARB;
                            ptr_d   = inc3(owner_q);
                            cnt_d   = '0;
                        end
                    end else begin
                        // Owner dropped its request: release, costing one idle cycle.
                        state_d = ARB;
                        ptr_d   = inc3(owner_q);
                        cnt_d   = '0;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    assign gnt = gnt_vld ? (3'b001 << gnt_port) : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            ptr_q     <= 2'd0;
            owner_q   <= 2'd0;
            cnt_q     <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rvalid    <= 3'b000;
            for (int i = 0; i < READ_LAT; i++) tag_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            // gnt_vld is already low during abort, so the strobes clear too.
            mem_ren <= gnt_vld & ~we[gnt_port];
            mem_wen <= gnt_vld & we[gnt_port];
            if (gnt_vld) begin
                mem_addr  <= addr[gnt_port*ADDR_W +: ADDR_W];
                mem_wdata <= wdata[gnt_port*DATA_W +: DATA_W];
            end
            if (abort) begin
                rvalid <= 3'b000;
                for (int i = 0; i < READ_LAT; i++) tag_q[i] <= '0;
            end else begin
                // Stage 0 lines up with mem_ren; the extra rvalid register
                // lines the return up with mem_rdata.
                tag_q[0] <= '{vld: gnt_vld & ~we[gnt_port], port: gnt_port};
                for (int i = 1; i < READ_LAT; i++) tag_q[i] <= tag_q[i-1];
                rvalid <= tag_q[READ_LAT-1].vld ? (3'b001 << tag_q[READ_LAT-1].port) : 3'b000;
            end
        end
    end

    always_comb begin
        any_tag = 1'b0;
        for (int i = 0; i < READ_LAT; i++) any_tag = any_tag | tag_q[i].vld;
    end

    assign busy  = (state_q == OWNED) | any_tag | (|rvalid);
    assign rdata = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed plus randomized stimulus for sram_arbiter against a behavioural model.
// Latency: model tracks grant cycle, strobe cycle and return cycle per access.
// Backpressure: bench requesters hold their request until granted.
module tb_sram_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int RL = 2;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst, abort;
    logic [2:0]      req, lock, we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt, rvalid;
    logic [DW-1:0]   rdata, mem_rdata, mem_wdata;
    logic            busy, mem_ren, mem_wen;
    logic [AW-1:0]   mem_addr;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .abort(abort), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .busy(busy), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment SRAM: data appears READ_LAT cycles after mem_ren is seen.
    logic [DW-1:0] env_mem [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    logic [DW-1:0] srp [RL];
    always @(posedge clk) begin
        srp[0] <= env_mem[mem_addr];
        for (int i = 1; i < RL; i++) srp[i] <= srp[i-1];
        if (mem_wen) env_mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = srp[RL-1];

    // Reference model: arbitration position, ownership, expected strobes, and
    // a queue of outstanding reads with their due cycle and data.
    typedef struct { int due; int port; logic [DW-1:0] data; } rd_t;
    rd_t           rq[$];
    int            m_ptr, m_owner, m_cnt, cyc, errors, checks;
    bit            m_owned, known, e_ren, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    last_gnt;
    logic [DW-1:0] seen_rdata;
    int            seen_cyc, rv_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick();
        if (rst || abort) return -1;
        if (m_owned) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < 3; k++) if (req[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        return -1;
    endfunction

    task automatic tick();
        int w;
        logic [2:0] eg, erv;
        logic [DW-1:0] ed;
        #1;
        w  = pick();
        eg = (w < 0) ? 3'b000 : (3'b001 << w);
        chk("gnt", gnt, eg);
        if (known) begin
            chk("mem_ren", mem_ren, e_ren);
            chk("mem_wen", mem_wen, e_wen);
            if (e_ren || e_wen) chk("mem_addr", mem_addr, e_addr);
            if (e_wen) chk("mem_wdata", mem_wdata, e_wdata);
            erv = 3'b000; ed = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                erv = 3'b001 << rq[0].port;
                ed  = rq[0].data;
            end
            chk("rvalid", rvalid, erv);
            if (erv != 3'b000) chk("rdata", rdata, ed);
            chk("busy", busy, m_owned || (rq.size() > 0));
        end
        last_gnt = gnt;
        if (rvalid[0]) begin seen_rdata = rdata; seen_cyc = cyc; end
        if (rvalid != 3'b000) rv_cnt++;
        @(posedge clk);
        cyc++;
        if (rq.size() > 0 && rq[0].due == cyc - 1) void'(rq.pop_front());
        e_ren = 1'b0; e_wen = 1'b0;
        if (rst || abort) begin
            m_owned = 1'b0; m_ptr = 0; m_cnt = 0; rq.delete();
            if (rst) begin known = 1'b1; m_owner = 0; end
        end else if (w >= 0) begin
            e_wen   = we[w];
            e_ren   = !we[w];
            e_addr  = addr[w*AW +: AW];
            e_wdata = wdata[w*DW +: DW];
            if (we[w]) ref_mem[e_addr] = e_wdata;
            else rq.push_back('{cyc + RL, w, ref_mem[e_addr]});
            if (!m_owned) begin
                if (lock[w] && MB > 1) begin m_owned = 1'b1; m_owner = w; m_cnt = 1; end
                else m_ptr = (w + 1) % 3;
            end else begin
                m_cnt++;
                if (!lock[w] || m_cnt == MB) begin m_owned = 1'b0; m_ptr = (w + 1) % 3; end
            end
        end else if (m_owned) begin
            m_owned = 1'b0; m_ptr = (m_owner + 1) % 3;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req = 3'b000; lock = 3'b000;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int rgc;
        logic [2:0] expa [4];
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5C;
            ref_mem[i] = env_mem[i];
        end
        errors = 0; checks = 0; cyc = 0; known = 1'b0; rv_cnt = 0;
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_owned = 1'b0; e_ren = 1'b0; e_wen = 1'b0;
        rst = 1'b1; abort = 1'b0; req = 3'b000; lock = 3'b000; we = 3'b000;
        addr = '0; wdata = '0; seen_cyc = -1; seen_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rvalid", rvalid, 3'b000);

        // All three reading: plain rotation 0,1,2,0.
        expa[0] = 3'b001; expa[1] = 3'b010; expa[2] = 3'b100; expa[3] = 3'b001;
        addr = {16'h0300, 16'h0200, 16'h0100};
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_order", last_gnt, expa[i]);
        end
        idle(RL + 3);
        chk("rr_drained_busy", busy, 1'b0);

        // Port 1 locked burst of MB, then 2, then 0.
        req = 3'b111; lock = 3'b010;
        for (int i = 0; i < MB; i++) begin tick(); chk("burst_p1", last_gnt, 3'b010); end
        tick(); chk("after_burst_p2", last_gnt, 3'b100);
        tick(); chk("after_burst_p0", last_gnt, 3'b001);
        idle(RL + 3);

        // Port 2 locked, drops after two grants: dead cycle then port 0.
        req = 3'b101; lock = 3'b100;
        tick(); chk("own_p2_a", last_gnt, 3'b100);
        tick(); chk("own_p2_b", last_gnt, 3'b100);
        req = 3'b001;
        tick(); chk("dead_cycle", last_gnt, 3'b000);
        tick(); chk("after_drop_p0", last_gnt, 3'b001);
        idle(RL + 3);
        chk("drop_busy", busy, 1'b0);

        // Write then read back on port 0.
        req = 3'b001; we = 3'b001; addr[15:0] = 16'h0010; wdata[7:0] = 8'hA5;
        tick(); chk("wr_gnt", last_gnt, 3'b001);
        we = 3'b000; rgc = cyc;
        tick(); chk("rd_gnt", last_gnt, 3'b001);
        idle(RL + 3);
        chk("rdback_data", seen_rdata, 8'hA5);
        chk("rdback_cycle", seen_cyc, rgc + RL + 1);

        // Two reads then abort: nothing returns.
        req = 3'b011;
        tick(); tick();
        rv_cnt = 0;
        abort = 1'b1;
        tick(); chk("abort_gnt", last_gnt, 3'b000);
        abort = 1'b0; req = 3'b000;
        chk("abort_busy", busy, 1'b0);
        idle(RL + 3);
        chk("abort_no_rvalid", rv_cnt, 0);
        req = 3'b100;
        tick(); chk("post_abort_p2", last_gnt, 3'b100);
        idle(RL + 3);

        // Reset in the middle of a locked burst with reads in flight.
        req = 3'b111; lock = 3'b111;
        tick(); tick(); tick();
        rst = 1'b1; req = 3'b000; lock = 3'b000;
        tick();
        rst = 1'b0;
        chk("midrst_out", {gnt, rvalid, busy, mem_ren, mem_wen}, 9'h000);
        chk("midrst_addr", mem_addr, 16'h0000);
        req = 3'b111;
        tick(); chk("midrst_restart", last_gnt, 3'b001);
        idle(RL + 3);

        // Random traffic; each port reloads only after its grant or while idle.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (last_gnt[i] || !req[i]) begin
                    req[i]  = ($urandom_range(0, 99) < 60);
                    we[i]   = ($urandom_range(0, 99) < 35);
                    lock[i] = ($urandom_range(0, 99) < 30);
                    addr[i*AW +: AW]  = {12'h004, 4'($urandom_range(0, 15))};
                    wdata[i*DW +: DW] = 8'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    lock[i] = ~lock[i];
                end
            end
            abort = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        abort = 1'b0; rst = 1'b0;
        idle(RL + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
